// File: rtl/sram_pkg.sv
// Shared definitions for the sram_burst_arb block.
//   SRAM_DATA_W / SRAM_ADDR_W / SRAM_BURST_W : default widths for the top level
//   state_t                                  : burst FSM state encoding
package sram_pkg;

    localparam int SRAM_DATA_W  = 8;
    localparam int SRAM_ADDR_W  = 13;
    localparam int SRAM_BURST_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   i_clk, i_rst_n : clock, synchronous active-low reset (pointer -> channel 0)
//   i_req          : per-channel request vector
//   i_advance      : grant is being taken this cycle; move priority past winner
//   o_gnt          : one-hot grant (combinational), zero when no request
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_gnt
);

    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     w_idx;
    logic [PW-1:0]     w_win;
    logic              w_found;
    logic [NUM_CH-1:0] w_gnt;

    // Scan channels starting at the pointer; first requester wins.
    always_comb begin
        w_gnt   = '0;
        w_win   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_idx = PW'((int'(r_ptr) + int'(k)) % NUM_CH);
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                w_gnt[w_idx] = 1'b1;
                w_win        = w_idx;
            end
        end
    end

    // Rotating at grant time is equivalent to rotating at burst end, since
    // the pointer is only consulted again once the burst has finished.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_win == PW'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/sram_burst_arb.sv
// Multi-channel burst front end over an inferred single-clock SRAM.
//   clk, rst_n : clock, synchronous active-low reset (memory not cleared)
//   ch_req     : per-channel burst request (level, sampled only at grant)
//   ch_we      : per-channel burst direction, 1 = write
//   ch_addr    : per-channel start address, channel i at [i*ADDR_W +: ADDR_W]
//   ch_len     : per-channel beats minus one
//   ch_wdata   : per-channel write beat data
//   ch_gnt     : one-hot, high on every beat cycle of the granted burst
//   rd_data    : read data, one cycle after the read beat
//   rd_valid   : one-hot owner of rd_data this cycle
//   busy       : burst in progress
module sram_burst_arb
    import sram_pkg::*;
#(
    parameter int DATA_W  = SRAM_DATA_W,
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int NUM_CH  = 2,
    parameter int BURST_W = SRAM_BURST_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH-1:0]         ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH*BURST_W-1:0] ch_len,
    input  logic [NUM_CH*DATA_W-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]         ch_gnt,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_CH-1:0]         rd_valid,
    output logic                      busy
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_W-1:0]  r_mem [0:(1<<ADDR_W)-1];

    state_t             r_state;
    logic [NUM_CH-1:0]  r_gnt;
    logic [NUM_CH-1:0]  r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_we;
    logic [ADDR_W-1:0]  r_start;
    logic [BURST_W-1:0] r_len;
    logic [BURST_W-1:0] r_beat;
    logic [CW-1:0]      r_ch;

    logic [NUM_CH-1:0]  w_arb_gnt;
    logic               w_advance;
    logic [CW-1:0]      w_win;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;

    assign w_advance = (r_state == ST_IDLE) && (|ch_req);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (ch_req),
        .i_advance (w_advance),
        .o_gnt     (w_arb_gnt)
    );

    always_comb begin
        w_win = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (w_arb_gnt[k]) begin
                w_win = CW'(k);
            end
        end
    end

    // Address wraps naturally modulo 2^ADDR_W.
    assign w_addr  = r_start + ADDR_W'(r_beat);
    assign w_wdata = ch_wdata[r_ch*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_we       <= 1'b0;
            r_start    <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_ch       <= '0;
        end else begin
            r_rd_valid <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_advance) begin
                        r_state <= ST_BURST;
                        r_gnt   <= w_arb_gnt;
                        r_ch    <= w_win;
                        r_we    <= ch_we[w_win];
                        r_start <= ch_addr[w_win*ADDR_W +: ADDR_W];
                        r_len   <= ch_len[w_win*BURST_W +: BURST_W];
                        r_beat  <= '0;
                    end
                end
                ST_BURST: begin
                    if (!r_we) begin
                        r_rd_data  <= r_mem[w_addr];
                        r_rd_valid <= r_gnt;
                    end
                    if (r_beat == r_len) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Write port kept free of reset so it maps to block RAM; the rst_n gate
    // drops the beat coinciding with a reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == ST_BURST) && r_we) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    assign ch_gnt   = r_gnt;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == ST_BURST);

endmodule

// File: tb/tb_sram_burst_arb.sv
module tb_sram_burst_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ch_req;
    logic [1:0]  ch_we;
    logic [25:0] ch_addr;
    logic [7:0]  ch_len;
    logic [15:0] ch_wdata;
    logic [1:0]  ch_gnt;
    logic [7:0]  rd_data;
    logic [1:0]  rd_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] wd [8];
    logic [7:0] rx [8];

    always #5 clk = ~clk;

    sram_burst_arb #(
        .DATA_W  (8),
        .ADDR_W  (13),
        .NUM_CH  (2),
        .BURST_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ch_req   (ch_req),
        .ch_we    (ch_we),
        .ch_addr  (ch_addr),
        .ch_len   (ch_len),
        .ch_wdata (ch_wdata),
        .ch_gnt   (ch_gnt),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int ch, input logic we, input logic [12:0] addr, input logic [3:0] len);
        ch_we[ch]            = we;
        ch_addr[ch*13 +: 13] = addr;
        ch_len[ch*4 +: 4]    = len;
        ch_req[ch]           = 1'b1;
    endtask

    // Write burst from wd[]; ends on the first IDLE cycle after the burst.
    task automatic wr_burst(input string nm, input int ch, input logic [12:0] addr, input int len);
        setup(ch, 1'b1, addr, 4'(len));
        tick();
        ch_req[ch] = 1'b0;
        check({nm, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k <= len; k++) begin
            check($sformatf("%s_gnt%0d", nm, k), 32'(ch_gnt), 32'(1 << ch));
            ch_wdata[ch*8 +: 8]     = wd[k];
            ch_wdata[(1-ch)*8 +: 8] = ~wd[k];
            tick();
        end
        check({nm, "_gnt_end"}, 32'(ch_gnt), 32'd0);
        check({nm, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    // Read burst checked against rx[]; request dropped and inputs scrambled at beat drop_at.
    task automatic rd_burst(input string nm, input int ch, input logic [12:0] addr, input int len, input int drop_at);
        setup(ch, 1'b0, addr, 4'(len));
        tick();
        for (int k = 0; k <= len; k++) begin
            check($sformatf("%s_gnt%0d", nm, k), 32'(ch_gnt), 32'(1 << ch));
            if (k == drop_at) begin
                ch_req[ch]           = 1'b0;
                ch_we[ch]            = 1'b1;
                ch_addr[ch*13 +: 13] = ~addr;
                ch_len[ch*4 +: 4]    = 4'd0;
            end
            tick();
            check($sformatf("%s_vld%0d", nm, k), 32'(rd_valid), 32'(1 << ch));
            check($sformatf("%s_dat%0d", nm, k), 32'(rd_data), 32'(rx[k]));
        end
        check({nm, "_gnt_end"}, 32'(ch_gnt), 32'd0);
        tick();
        check({nm, "_vld_end"}, 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        ch_req   = '0;
        ch_we    = '0;
        ch_addr  = '0;
        ch_len   = '0;
        ch_wdata = '0;
        tick();
        tick();
        check("rst_gnt",   32'(ch_gnt),   32'd0);
        check("rst_vld",   32'(rd_valid), 32'd0);
        check("rst_data",  32'(rd_data),  32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        rst_n = 1'b1;
        tick();

        // Contention: both channels, single-beat reads
        setup(0, 1'b0, 13'h0000, 4'd0);
        setup(1, 1'b0, 13'h0000, 4'd0);
        tick();
        check("cont_first",  32'(ch_gnt), 32'd1);
        check("cont_busy",   32'(busy),   32'd1);
        tick();
        check("cont_idle1",  32'(ch_gnt), 32'd0);
        check("cont_ibusy",  32'(busy),   32'd0);
        tick();
        check("cont_second", 32'(ch_gnt), 32'd2);
        tick();
        check("cont_idle2",  32'(ch_gnt), 32'd0);
        tick();
        check("cont_rotate", 32'(ch_gnt), 32'd1);
        ch_req = '0;
        tick();
        tick();

        // Write/read-back at 0x0010
        wd = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
        wr_burst("wr10", 0, 13'h0010, 3);
        rx = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00};
        rd_burst("rd10", 0, 13'h0010, 3, 0);

        // Wrap-around past top of memory
        wd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        wr_burst("wrwrap", 1, 13'h1FFE, 3);
        rx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        rd_burst("rdwrap", 0, 13'h1FFE, 3, 0);
        rx = '{8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rd_burst("rdlow", 1, 13'h0000, 1, 0);

        // Request drop mid-burst: 8-beat read must complete
        wd = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
        wr_burst("wr100", 0, 13'h0100, 7);
        rx = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
        rd_burst("rddrop", 1, 13'h0100, 7, 2);

        // Reset during beat 2 of a 6-beat write over known contents
        wd = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h00, 8'h00};
        wr_burst("wr200", 0, 13'h0200, 5);
        setup(0, 1'b1, 13'h0200, 4'd5);
        tick();
        ch_req[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rstb_gnt%0d", k), 32'(ch_gnt), 32'd1);
            ch_wdata[7:0] = 8'hC0 + 8'(k);
            tick();
        end
        ch_wdata[7:0] = 8'hC2;
        rst_n = 1'b0;
        tick();
        check("rstb_gnt", 32'(ch_gnt),   32'd0);
        check("rstb_busy", 32'(busy),    32'd0);
        check("rstb_vld", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        rx = '{8'hC0, 8'hC1, 8'h52, 8'h53, 8'h54, 8'h55, 8'h00, 8'h00};
        rd_burst("rdrst", 0, 13'h0200, 5, 0);

        // Single-beat write then read
        wd = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        wr_burst("wr1", 1, 13'h0ABC, 0);
        rx = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rd_burst("rd1", 1, 13'h0ABC, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
